// File: rtl/disp_channel_sequencer_pkg.sv
// ============================================================================
// Module   : disp_pkg
// Purpose  : Shared types and default constants for the display channel
//            sequencer and its button debouncer.
// Contents : deb_state_t   - debouncer FSM states
//            NCH_MAX       - upper bound on observed channels
//            *_50M         - default cycle counts for a 50 MHz clock
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int NCH_MAX         = 16;
  localparam int DEB_CYCLES_50M  = 1_000_000;   // 20 ms at 50 MHz
  localparam int AUTO_CYCLES_50M = 50_000_000;  // 1 s at 50 MHz

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

endpackage : disp_pkg

`default_nettype wire

// File: rtl/disp_channel_sequencer_if.sv
// ============================================================================
// Module   : disp_channel_sequencer_if
// Purpose  : Board-side bundle of the channel sequencer: button/switch
//            inputs, observed channel bus and the display-stage outputs.
// Signals  : btn_next_n  raw active-low push-button
//            auto_en     auto-advance enable switch
//            freeze      snapshot-hold switch
//            ch_data     NCH packed 8-bit channel values
//            num         selected value to the display stage
//            letter      selected channel index to the display stage
//            adv_pulse   one-cycle pulse on every channel advance
// Modports : master - drives inputs, observes outputs (board / bench)
//            slave  - the sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface disp_channel_sequencer_if #(
  parameter int NCH = 4
) ();
  import disp_pkg::*;

  logic             btn_next_n;
  logic             auto_en;
  logic             freeze;
  logic [NCH*8-1:0] ch_data;
  logic [7:0]       num;
  logic [3:0]       letter;
  logic             adv_pulse;

  modport master (
    output btn_next_n, auto_en, freeze, ch_data,
    input  num, letter, adv_pulse
  );

  modport slave (
    input  btn_next_n, auto_en, freeze, ch_data,
    output num, letter, adv_pulse
  );

endinterface : disp_channel_sequencer_if

`default_nettype wire

// File: rtl/disp_channel_sequencer_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronizes a raw active-low push-button and debounces it,
//            emitting exactly one press event per physical press. Holding
//            the button never repeats the event.
// Ports    : clk         system clock, rising edge
//            reset       asynchronous active-high reset
//            i_btn_n     raw button, active-low, asynchronous to clk
//            o_press_evt one-cycle pulse when a press is accepted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import disp_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_50M
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press_evt
);

  localparam int              c_cnt_w    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  // Synchronizer flops reset to 1 so the button reads as released.
  logic               r_sync1;
  logic               r_sync2;
  logic               w_btn;
  deb_state_t         r_state;
  deb_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;

  assign w_btn = ~r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_press_evt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn) begin
          w_cnt_nxt   = '0;
          w_state_nxt = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!w_btn) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == c_cnt_last) begin
          // Event fires on the accepting transition only, so a held
          // button sits in PRESSED without further events.
          w_state_nxt = PRESSED;
          o_press_evt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      PRESSED: begin
        if (!w_btn) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed is not a new press.
        if (w_btn) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : btn_debounce

`default_nettype wire

// File: rtl/disp_channel_sequencer.sv
// ============================================================================
// Module   : disp_channel_sequencer
// Purpose  : Upstream feeder for the 7-segment display stage. Selects one of
//            NCH 8-bit observation channels by debounced push-button or an
//            auto-scroll timer, with an optional freeze of the shown value.
// Ports    : clk    system clock, rising edge
//            reset  asynchronous active-high reset
//            bus    disp_channel_sequencer_if.slave
//                   (btn_next_n, auto_en, freeze, ch_data in;
//                    num, letter, adv_pulse out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_channel_sequencer
  import disp_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DEB_CYCLES  = DEB_CYCLES_50M,
  parameter int AUTO_CYCLES = AUTO_CYCLES_50M
) (
  input  logic                     clk,
  input  logic                     reset,
  disp_channel_sequencer_if.slave  bus
);

  localparam int c_idx_w = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_tmr_w = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NCH - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(AUTO_CYCLES - 1);

  logic               w_press_evt;
  logic               w_auto_tick;
  logic               w_adv;
  logic [c_idx_w-1:0] r_index;
  logic [c_idx_w-1:0] w_index_nxt;
  logic [c_tmr_w-1:0] r_timer;
  logic [7:0]         r_num;
  logic [3:0]         r_letter;
  logic               r_adv_pulse;
  logic [7:0]         w_ch [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_ch_slice
    assign w_ch[k] = bus.ch_data[8*k +: 8];
  end

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_next (
    .clk         (clk),
    .reset       (reset),
    .i_btn_n     (bus.btn_next_n),
    .o_press_evt (w_press_evt)
  );

  // A press and a tick in the same cycle merge into a single advance.
  assign w_auto_tick = bus.auto_en && (r_timer == c_tmr_last);
  assign w_adv       = w_press_evt | w_auto_tick;

  always_comb begin
    w_index_nxt = r_index;
    if (w_adv) begin
      w_index_nxt = (r_index == c_idx_last) ? '0 : r_index + c_idx_w'(1);
    end
  end

  // Any advance (including a press) restarts the auto interval, so the
  // next tick is always a full period after the last advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (!bus.auto_en || w_adv) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_tmr_w'(1);
    end
  end

  // letter is loaded from the next index so it lines up with adv_pulse;
  // num samples the current index and therefore trails letter by a cycle.
  // While frozen, the cycle after an advance still loads the new channel
  // once so the shown value matches the shown letter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index     <= '0;
      r_letter    <= 4'h0;
      r_adv_pulse <= 1'b0;
      r_num       <= 8'h00;
    end else begin
      r_index     <= w_index_nxt;
      r_letter    <= 4'(w_index_nxt);
      r_adv_pulse <= w_adv;
      if (!bus.freeze || r_adv_pulse) begin
        r_num <= w_ch[r_index];
      end
    end
  end

  assign bus.num       = r_num;
  assign bus.letter    = r_letter;
  assign bus.adv_pulse = r_adv_pulse;

endmodule : disp_channel_sequencer

`default_nettype wire

// File: doc/disp_channel_sequencer.md
Name: disp_channel_sequencer

Overview:
- Upstream feeder for the 7-segment display stage. It produces the signed 8-bit `num` and 4-bit `letter` that the display stage renders.
- Selects one of NCH 8-bit processor observation channels, for example low bytes of debug registers or ALU result.
- Channel is selected by a debounced push-button or by an optional auto-scroll timer.
- An optional freeze switch holds a snapshot of the selected value.

Parameters:
- NCH, 4, number of observed channels (2..16); sets the ch_data width and the index wrap point.
- DEB_CYCLES, 1_000_000, cycles the synchronized button must be stable to be accepted (20 ms at 50 MHz).
- AUTO_CYCLES, 50_000_000, cycles between auto-advance ticks (1 s at 50 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_next_n  in  1  raw push-button, active-low, asynchronous to clk.
- auto_en  in  1  slide switch; 1 enables auto-advance.
- freeze  in  1  slide switch; 1 holds the current num.
- ch_data  in  NCH*8  packed channel values; channel k is ch_data[8k+7:8k], two's complement.
- num  out  8  selected value, registered, to the display stage.
- letter  out  4  selected channel index, registered, to the display stage.
- adv_pulse  out  1  one-cycle pulse on every channel advance.

Behaviour:
- Interface: one clock, clk. Asynchronous active-high reset on reset; all flops clear immediately on assertion.
- Reset values:
  - num = 8'h00, letter = 4'h0, adv_pulse = 0.
  - Channel index = 0, auto timer = 0.
  - Debouncer in IDLE, counter = 0, synchronizer flops = 1 (button released).
- Input synchronization: btn_next_n passes through a 2-flop synchronizer, then is inverted to give btn (1 = pressed).
- Debouncer FSM:
  - IDLE: when btn = 1, clear counter and go to PRESS_WAIT.
  - PRESS_WAIT: counter increments while btn = 1. Any btn = 0 returns to IDLE. When counter reaches DEB_CYCLES-1, go to PRESSED and assert press_evt for exactly one cycle.
  - PRESSED: when btn = 0, clear counter and go to RELEASE_WAIT.
  - RELEASE_WAIT: counter increments while btn = 0. Any btn = 1 returns to PRESSED. When counter reaches DEB_CYCLES-1, go to IDLE.
  - Result: one press_evt per physical press. Holding the button never repeats.
- Auto timer:
  - Counts only while auto_enables = 1.
  - At AUTO_CYCLES-1 it generates auto_tick and wraps to 0.
  - auto_en = 0 clears the timer to 0.
- Advance:
  - adv = press_evt OR auto_tick.
  - On adv, index <= (index == NCH-1) ? 0 : index+1, and the auto timer clears to 0.
  - Simultaneous press_evt and auto_tick advance by exactly one.
  - adv_pulse is adv registered (1 cycle late, aligned with the new letter).
- Output register:
  - letter <= index every cycle (zero-extended to 4 bits).
  - While freeze = 0: num <= ch_data slice of the current index every cycle. num lags ch_data by 1 cycle, and lags an index change by 1 cycle.
  - While freeze = 1: num holds its value, while index and letter still follow advances.
  - Exception: on any advance while freeze = 1, num loads the new channel's value once, then holds.
  - freeze falling edge: num resumes tracking on the next cycle.
- Arithmetic: no arithmetic on num. The value is passed through bit-exact; sign handling belongs to the display stage. Index counter width is $clog2(NCH), minimum 1.
- Reset mid-debounce or mid-timer: returns to the reset state. A button held through reset release produces one press_evt after DEB_CYCLES; it is not lost.

Decomposition:
- Package disp_pkg:
  - deb_state_t enum {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - localparam NCH_MAX = 16.
  - Default constants DEB_CYCLES_50M and AUTO_CYCLES_50M.
- One sub-module, btn_debounce (synchronizer + FSM + counter, parameter DEB_CYCLES). It outputs press_evt and is reusable for other board buttons.
- Index, timer and output registers stay in disp_channel_sequencer.

Test Plan (bench uses DEB_CYCLES=4, AUTO_CYCLES=16, NCH=4; ch_data = {8'hF6, 8'h7F, 8'h80, 8'h05}):
- Reset, then idle 10 cycles -> letter=0, num=8'h05, adv_pulse never asserted.
- btn_next_n low for 10 cycles, then high for 10 -> exactly one adv_pulse; letter=1, num=8'h80 one cycle after the pulse.
- Glitch: btn_next_n low for 2 cycles, high, repeated 5 times -> no advance, letter unchanged.
- auto_en=1 with four clean presses interleaved -> index wraps 3->0. A press landing on the same cycle as auto_tick advances by one only; the next tick comes 16 cycles later.
- freeze=1 on channel 2 (num=8'h7F), then change ch_data[23:16] to 8'h11 -> num stays 8'h7F. Press -> letter=3, num=8'hF6 and holds. freeze=0 -> num tracks live data next cycle.
- Assert reset while in PRESS_WAIT and with the timer at 10 -> outputs clear asynchronously, same cycle. Release reset with button held -> one adv after 4 stable cycles.
